comparator_pipe_n: RTL and testbench
====================================

Name: comparator_pipe_n

Overview:
- Parametrised, pipelined magnitude comparator. Successor to the team's fixed 8-bit combinational comparator.
- Resolves A vs B over WIDTH bits, SLICE bits per pipeline stage, MSB slice first.
- Supports per-transaction signed or unsigned mode and valid/ready handshakes on both sides.
- Sits between datapath producers and control logic that needs LT/GT/EQ at high clock rates for wide operands.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of SLICE and at least SLICE.
- SLICE, 8, bits resolved per pipeline stage. STAGES = WIDTH/SLICE.
- TAG_W, 4, width of a user tag carried alongside each transaction.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned
- in_tag  in  TAG_W  user tag, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- lt  out  1  A < B
- gt  out  1  A > B
- eq  out  1  A == B
- out_tag  out  TAG_W  tag of the transaction being presented

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n is low: all stage valids, out_valid, lt, gt and eq are 0; out_tag is 0.
  - in_ready is 1 while out_valid is 0.
- Handshake:
  - Input is accepted when in_valid && in_ready. Output transfers when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a global stall: when the last stage holds a result and out_ready is low, every stage holds.
  - No combinational path from in_valid to out_valid.
  - in_ready may depend combinationally on out_ready.
- Stage k (k = 0..STAGES-1) examines slice [WIDTH-1-k*SLICE -: SLICE]. Each stage register carries:
  - valid, decided, result (LT/GT/EQ), signed_mode, tag;
  - the not-yet-examined lower bits of a and b.
- Stage 0, signed_mode = 1: invert the MSB of both top slices before an unsigned slice compare (offset-binary trick). Lower slices are always compared unsigned.
- If decided is already set, a stage passes its result through unchanged. Otherwise the slice compare sets the result; decided is set when the slices differ.
- Last stage: if nothing was decided, the result is EQ.
- Exactly one of lt/gt/eq is 1 whenever out_valid is 1. All three are 0 whenever out_valid is 0.
- Latency: a transaction accepted in cycle N is presented on out_valid in cycle N+STAGES, absent stalls.
  - Throughput is one transaction per cycle with out_ready held high.
  - STAGES = 1 degenerates to a single registered compare with latency 1.
- Stall behaviour:
  - lt/gt/eq/out_tag are stable while out_valid && !out_ready.
  - No transaction is dropped or duplicated; order is preserved.
- Bubbles: an empty stage advances even during stall conditions upstream of it. This is optional. The required behaviour is only the global-stall rule above; bubble collapse is not required.
- signed_mode and in_tag are captured per transaction. Changing them while a transaction is in flight affects only later transactions.
- Reset mid-operation: all in-flight transactions are discarded. The first valid output after reset release belongs to a transaction accepted after release.

Decomposition:
- Shared package cmp_pkg holds:
  - enum cmp_result_t {CMP_EQ, CMP_LT, CMP_GT};
  - function cmp_stages(width, slice) returning width/slice;
  - struct cmp_stage_t {valid, decided, result, signed_mode, tag}, parameterised via the top-level widths.
- One sub-module: cmp_slice_stage.
  - Contains one pipeline register stage plus the SLICE-bit compare and pass-through logic.
  - Instantiated STAGES times in a generate loop.
  - Takes the stall enable from the top level.

Test Plan:
- Basic compares, WIDTH=32/SLICE=8, out_ready=1:
  - a=0x0000_0005, b=0x0000_0003, unsigned -> gt=1 at exactly 4 cycles after accept;
  - a=b=0xDEAD_BEEF -> eq=1.
- Signed mode: a=0xFFFF_FFFF, b=0x0000_0000.
  - signed_mode=1 -> lt=1.
  - Same operands, signed_mode=0 -> gt=1.
  - a=0x8000_0000, b=0x7FFF_FFFF, signed -> lt=1.
- Late decision: a=0x1234_5600, b=0x1234_5601 (differ only in LSB slice) -> lt=1; tag=0xA returned on out_tag.
- Back-to-back throughput: 16 random pairs on consecutive cycles, out_ready=1 -> 16 results on consecutive cycles, matching a reference model and in-order tags.
- Backpressure: stream 8 pairs, drop out_ready for 5 cycles mid-stream.
  - in_ready falls in the same cycle as out_valid && !out_ready.
  - Outputs hold stable; after release all 8 results arrive in order with none lost.
- Reset mid-operation: assert rst_n=0 with 3 transactions in flight.
  - out_valid=0 and lt=gt=eq=0 immediately (asynchronous).
  - After release, no stale result appears; the next accepted pair yields its correct result after 4 cycles.

Source files
------------

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared types and helpers for the pipelined magnitude comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    // Tags up to this width ride in the stage record; narrower tags use the low bits.
    localparam int CMP_TAG_W_MAX = 16;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_t;

    typedef struct packed {
        logic                      valid;
        logic                      decided;
        cmp_result_t               result;
        logic                      signed_mode;
        logic [CMP_TAG_W_MAX-1:0]  tag;
    } cmp_stage_t;

    function automatic int cmp_stages(input int width, input int slice);
        return width / slice;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_slice_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_slice_stage
//  Description : One comparator pipeline stage: SLICE-bit compare plus register.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_slice_stage
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter bit FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  cmp_stage_t        i_stage,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output cmp_stage_t        o_stage,
    output logic [WIDTH-1:0]  o_a,
    output logic [WIDTH-1:0]  o_b
);

    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    cmp_result_t      w_result;
    cmp_stage_t       r_stage;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    // The slice under test is always at the top; operands shift up each stage.
    always_comb begin
        w_a_sl = i_a[WIDTH-1 -: SLICE];
        w_b_sl = i_b[WIDTH-1 -: SLICE];
        if (FIRST && i_stage.signed_mode) begin
            w_a_sl[SLICE-1] = ~w_a_sl[SLICE-1];
            w_b_sl[SLICE-1] = ~w_b_sl[SLICE-1];
        end
        if (w_a_sl < w_b_sl)
            w_result = CMP_LT;
        else if (w_a_sl > w_b_sl)
            w_result = CMP_GT;
        else
            w_result = CMP_EQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (i_en) begin
            r_a <= i_a << SLICE;
            r_b <= i_b << SLICE;
            if (!i_stage.valid) begin
                r_stage <= '0;
            end else begin
                r_stage <= i_stage;
                if (!i_stage.decided) begin
                    r_stage.decided <= (w_result != CMP_EQ);
                    r_stage.result  <= w_result;
                end
            end
        end
    end

    assign o_stage = r_stage;
    assign o_a     = r_a;
    assign o_b     = r_b;

endmodule
`default_nettype wire

// File: rtl/comparator_pipe_n.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_pipe_n
//  Description : Pipelined WIDTH-bit signed/unsigned comparator, MSB slice first.
//  Revision    : 1.0 - initial release
// ============================================================================
module comparator_pipe_n
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              signed_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              lt,
    output logic              gt,
    output logic              eq,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int STAGES = cmp_stages(WIDTH, SLICE);

    cmp_stage_t       w_stage [0:STAGES];
    logic [WIDTH-1:0] w_a     [0:STAGES];
    logic [WIDTH-1:0] w_b     [0:STAGES];
    logic             w_en;
    logic             w_unused;

    // Global stall: every stage advances only when the output slot can move.
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    always_comb begin
        w_stage[0]                  = '0;
        w_stage[0].valid            = in_valid;
        w_stage[0].signed_mode      = signed_mode;
        w_stage[0].tag[TAG_W-1:0]   = in_tag;
    end
    assign w_a[0] = a;
    assign w_b[0] = b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cmp_slice_stage #(
            .WIDTH (WIDTH),
            .SLICE (SLICE),
            .FIRST (k == 0)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en),
            .i_stage (w_stage[k]),
            .i_a     (w_a[k]),
            .i_b     (w_b[k]),
            .o_stage (w_stage[k+1]),
            .o_a     (w_a[k+1]),
            .o_b     (w_b[k+1])
        );
    end

    // An undecided transaction leaves the last stage with CMP_EQ already set.
    assign out_valid = w_stage[STAGES].valid;
    assign lt        = w_stage[STAGES].valid && (w_stage[STAGES].result == CMP_LT);
    assign gt        = w_stage[STAGES].valid && (w_stage[STAGES].result == CMP_GT);
    assign eq        = w_stage[STAGES].valid && (w_stage[STAGES].result == CMP_EQ);
    assign out_tag   = w_stage[STAGES].tag[TAG_W-1:0];

    assign w_unused = ^{w_a[STAGES], w_b[STAGES], w_stage[STAGES].decided,
                        w_stage[STAGES].signed_mode, w_stage[STAGES].tag};

endmodule
`default_nettype wire

// File: tb/tb_comparator_pipe_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparator_pipe_n
//  Description : Self-checking bench for comparator_pipe_n (32-bit, 8-bit slices).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_pipe_n;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int TAG_W  = 4;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready;
    logic             out_valid;
    logic             lt;
    logic             gt;
    logic             eq;
    logic [TAG_W-1:0] out_tag;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_xfer = 0;
    int         n_stall = 0;
    logic [6:0] q[$];
    logic       held = 1'b0;
    logic [6:0] prev = '0;

    comparator_pipe_n #(.WIDTH(WIDTH), .SLICE(SLICE), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .lt          (lt),
        .gt          (gt),
        .eq          (eq),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer comparison, {lt, gt, eq}.
    function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y, input logic sm);
        logic l, g;
        if (sm) begin
            l = $signed(x) < $signed(y);
            g = $signed(x) > $signed(y);
        end else begin
            l = x < y;
            g = x > y;
        end
        return {l, g, (x == y)};
    endfunction

    always @(negedge rst_n) q.delete();

    // Compare process: every cycle, mid-period, against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (!out_valid) begin
                check("idle_flags", {lt, gt, eq}, 3'b000);
            end else begin
                check("model_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    check("out_result", {lt, gt, eq, out_tag}, q[0]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_xfer++;
                    end
                end
                if (held) check("stall_stable", {lt, gt, eq, out_tag}, prev);
                if (!out_ready) n_stall++;
            end
            held = out_valid && !out_ready;
            prev = {lt, gt, eq, out_tag};
            if (in_valid && in_ready) q.push_back({ref_cmp(a, b, signed_mode), in_tag});
        end
    end

    task automatic run_one(input logic [31:0] ia, input logic [31:0] ib, input logic sm,
                           input logic [3:0] tg, input logic [2:0] exp);
        int acc;
        int guard;
        @(posedge clk); #1;
        a = ia; b = ib; signed_mode = sm; in_tag = tg; in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin guard++; @(negedge clk); end
        check("accept", in_ready, 1'b1);
        acc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ia; b = ~ib; signed_mode = ~sm; in_tag = ~tg;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin guard++; @(negedge clk); end
        check("latency", cyc - acc, STAGES);
        check("result", {lt, gt, eq}, exp);
        check("tag", out_tag, tg);
    endtask

    task automatic stream(input int n);
        int guard;
        logic [31:0] ra, rb;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ra = $urandom; rb = $urandom;
            case (i % 4)
                0:       rb = ra;
                1:       rb = {ra[31:8], rb[7:0]};
                2:       rb = {ra[31:16], rb[15:0]};
                default: ;
            endcase
            a = ra; b = rb; signed_mode = 1'($urandom_range(0, 1)); in_tag = 4'(i); in_valid = 1'b1;
            guard = 0;
            @(negedge clk);
            while (!in_ready && guard < 50) begin guard++; @(negedge clk); end
            if (!in_ready) check("stream_accept", in_ready, 1'b1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && guard < 100) begin guard++; @(negedge clk); end
        check("drain", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, s0, run, guard;

        // Asynchronous reset with no clock edge needed.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_flags", {lt, gt, eq}, 3'b000);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);
        #22;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;

        // Directed vectors with literal expectations {lt,gt,eq}.
        run_one(32'h0000_0005, 32'h0000_0003, 1'b0, 4'h1, 3'b010);
        run_one(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'h2, 3'b001);
        run_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'h3, 3'b100);
        run_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 4'h4, 3'b010);
        run_one(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'h5, 3'b100);
        run_one(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 4'h6, 3'b100);
        run_one(32'h1234_5600, 32'h1234_5601, 1'b0, 4'hA, 3'b100);
        drain();

        // Back-to-back: 16 results on consecutive cycles.
        fork
            stream(16);
            begin
                guard = 0;
                @(negedge clk);
                while (!out_valid && guard < 40) begin guard++; @(negedge clk); end
                run = 0;
                while (out_valid && run < 40) begin run++; @(negedge clk); end
                check("b2b_run", run, 16);
            end
        join
        drain();

        // Backpressure: out_ready low for 5 cycles mid-stream.
        x0 = n_xfer; s0 = n_stall;
        fork
            stream(8);
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_xfer - x0, 8);
        check("bp_stall_cycles", n_stall - s0, 5);

        // Reset with three transactions in flight (one stalled at the output).
        @(posedge clk); #1 out_ready = 1'b0;
        stream(3);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin guard++; @(negedge clk); end
        check("pre_rst_valid", out_valid, 1'b1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_flags", {lt, gt, eq}, 3'b000);
        check("mid_rst_out_tag", out_tag, 4'h0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        #20 out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        run_one(32'h0000_0100, 32'h0000_00FF, 1'b0, 4'hC, 3'b010);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
